// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer driving the locked data-memory wrapper port.
// Optional grant-wait timeout enabled by defining MAU_GRANT_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_is_store,
    input  logic [31:0]         op_addr,
    input  logic [31:0]         op_wdata,
    input  logic [ID_WIDTH-1:0] op_issue_id,
    input  logic                store_commit,
    input  logic                flush,
    output logic [31:0]         mem_addr,
    output logic                mem_req_read,
    output logic                mem_req_write,
    output logic [ID_WIDTH-1:0] mem_issue_id,
    output logic                mem_release_lock,
    output logic                mem_write_commit,
    output logic [31:0]         mem_wdata,
    input  logic                mem_grant,
    input  logic [31:0]         mem_rdata,
    output logic                res_valid,
    output logic [31:0]         res_data,
    output logic [ID_WIDTH-1:0] res_issue_id,
    output logic                res_misaligned,
    output logic                res_timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HOLD    = 3'd2,
        S_RELEASE = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_is_store;
    logic [31:0]           r_rdata;
    logic                  r_flushed;
    logic                  r_timeout;
    logic                  w_accept;
    logic                  w_timeout;

    assign w_accept = op_valid & (r_state == S_IDLE);

`ifdef MAU_GRANT_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] r_cnt;

    // Fires on the last permitted grant-less REQ cycle; a grant in that cycle wins.
    assign w_timeout = (r_state == S_REQ) & ~mem_grant & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && !mem_grant) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (op_addr[1:0] != 2'b00) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    w_next = S_RELEASE;
                end else if (mem_grant) begin
                    w_next = r_is_store ? S_HOLD : S_RELEASE;
                end else if (w_timeout) begin
                    w_next = S_RELEASE;
                end
            end
            S_HOLD: begin
                if (flush || (store_commit && mem_grant)) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_id       <= '0;
            r_is_store <= 1'b0;
            r_rdata    <= '0;
            r_flushed  <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= op_addr;
            r_wdata    <= op_wdata;
            r_id       <= op_issue_id;
            r_is_store <= op_is_store;
            r_rdata    <= '0;
            r_flushed  <= 1'b0;
            r_timeout  <= 1'b0;
        end else if ((r_state == S_REQ) || (r_state == S_HOLD)) begin
            if (flush) begin
                r_flushed <= 1'b1;
            end else if ((r_state == S_REQ) && mem_grant && !r_is_store) begin
                r_rdata <= mem_rdata;
            end else if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign op_ready         = (r_state == S_IDLE);
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign mem_issue_id     = r_id;
    assign mem_req_read     = (r_state == S_REQ) & ~r_is_store;
    assign mem_req_write    = ((r_state == S_REQ) | (r_state == S_HOLD)) & r_is_store;
    // A reset arriving in HOLD abandons the store, so it must never strobe the write.
    assign mem_write_commit = (r_state == S_HOLD) & store_commit & mem_grant & ~flush & ~reset;
    assign mem_release_lock = (r_state == S_RELEASE);

    assign res_valid      = (r_state == S_ERR) | ((r_state == S_RELEASE) & ~r_flushed);
    assign res_data       = ((r_state == S_RELEASE) & ~r_flushed & ~r_is_store & ~r_timeout)
                            ? r_rdata : 32'd0;
    assign res_issue_id   = res_valid ? r_id : '0;
    assign res_misaligned = (r_state == S_ERR);
    assign res_timeout    = (r_state == S_RELEASE) & ~r_flushed & r_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        op_is_store = 1'b0;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic [3:0]  op_issue_id = '0;
    logic        store_commit = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req_read;
    logic        mem_req_write;
    logic [3:0]  mem_issue_id;
    logic        mem_release_lock;
    logic        mem_write_commit;
    logic [31:0] mem_wdata;
    logic        mem_grant = 1'b0;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_issue_id;
    logic        res_misaligned;
    logic        res_timeout;

    logic [31:0] wmem    [16];
    logic [31:0] ref_mem [16];
    int n_tests = 0;
    int n_fail  = 0;

    localparam int TIMEOUT = 256;

    always #5 clock = ~clock;

    assign mem_rdata = wmem[mem_addr[5:2]];

    mem_access_unit #(.ID_WIDTH(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_issue_id(op_issue_id),
        .store_commit(store_commit), .flush(flush),
        .mem_addr(mem_addr), .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
        .mem_issue_id(mem_issue_id), .mem_release_lock(mem_release_lock),
        .mem_write_commit(mem_write_commit), .mem_wdata(mem_wdata),
        .mem_grant(mem_grant), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_data(res_data), .res_issue_id(res_issue_id),
        .res_misaligned(res_misaligned), .res_timeout(res_timeout)
    );

`define CHK(tag, obs, exp) begin n_tests++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

    // g: REQ cycle of first grant; c: cycle store_commit is offered; f: flush cycle (-1 none).
    // Cycle 0 is the first cycle after the accept edge.
    task automatic run_op(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] id, input int g, input int c, input int f);
        logic [3:0]  idx = addr[5:2];
        logic        mis = (addr[1:0] != 2'b00);
        logic        flushed = 1'b0;
        logic        e_to = 1'b0;
        logic [31:0] e_data = '0;
        int limit = 0, stop = -1, e_rel = -1, e_res = -1, e_wr = -1, e_end = 1;
        int rel_cnt = 0, rel_cyc = -1, res_cnt = 0, res_cyc = -1;
        int wc_cnt = 0, wc_cyc = -1, end_cyc = -1, bad_req = 0;
        logic [31:0] g_data = '0, g_addr = '0;
        logic [3:0]  g_id = '0;
        logic        g_mis = 1'b0, g_to = 1'b0;

        if (mis) begin
            e_res = 0;
            e_end = 1;
        end else begin
            limit = st ? c : g;
`ifdef MAU_GRANT_TIMEOUT_EN
            if (g >= TIMEOUT) begin
                limit = TIMEOUT - 1;
                e_to  = 1'b1;
            end
`endif
            flushed = (f >= 0) && (f <= limit);
            if (flushed) e_to = 1'b0;
            stop   = flushed ? f : limit;
            e_rel  = stop + 1;
            e_res  = flushed ? -1 : stop + 1;
            e_wr   = (st && !flushed && !e_to) ? c : -1;
            e_data = (!st && !flushed && !e_to) ? ref_mem[idx] : 32'd0;
            e_end  = stop + 2;
        end

        for (int w = 0; w < 20 && !op_ready; w++) @(negedge clock);
        `CHK("op_ready_before_op", op_ready, 1'b1)
        op_valid = 1'b1; op_is_store = st; op_addr = addr; op_wdata = wd; op_issue_id = id;
        @(posedge clock); #1;
        op_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            mem_grant    = !mis && (k >= g) && (k <= stop);
            store_commit = st && (k == c);
            flush        = (k == f);
            @(negedge clock);
            if (k == 0) g_addr = mem_addr;
            if (res_valid) begin
                res_cnt++; res_cyc = k;
                g_data = res_data; g_id = res_issue_id; g_mis = res_misaligned; g_to = res_timeout;
            end
            if (mem_write_commit) begin
                wc_cnt++; wc_cyc = k;
                wmem[mem_addr[5:2]] = mem_wdata;
            end
            if (mem_release_lock) begin
                rel_cnt++; rel_cyc = k;
            end
            if ((mem_req_read && (mis || st)) || (mem_req_write && (mis || !st))) bad_req++;
            if (op_ready) begin
                end_cyc = k;
                break;
            end
            @(posedge clock); #1;
        end
        mem_grant = 1'b0; store_commit = 1'b0; flush = 1'b0;

        `CHK("mem_addr", g_addr, addr)
        `CHK("release_count", rel_cnt, (e_rel >= 0) ? 1 : 0)
        `CHK("release_cycle", rel_cyc, e_rel)
        `CHK("res_count", res_cnt, (e_res >= 0) ? 1 : 0)
        `CHK("res_cycle", res_cyc, e_res)
        if (e_res >= 0) begin
            `CHK("res_data", g_data, e_data)
            `CHK("res_issue_id", g_id, id)
            `CHK("res_misaligned", g_mis, mis)
            `CHK("res_timeout", g_to, e_to)
        end
        `CHK("write_count", wc_cnt, (e_wr >= 0) ? 1 : 0)
        `CHK("write_cycle", wc_cyc, e_wr)
        `CHK("ready_cycle", end_cyc, e_end)
        `CHK("bad_request", bad_req, 0)
        if (e_wr >= 0) ref_mem[idx] = wd;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            wmem[i]    = $urandom;
            ref_mem[i] = wmem[i];
        end
        wmem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        repeat (3) @(negedge clock);
        `CHK("reset_op_ready", op_ready, 1'b1)
        `CHK("reset_req", {mem_req_read, mem_req_write, mem_release_lock, mem_write_commit}, 4'b0)
        `CHK("reset_res", {res_valid, res_misaligned, res_timeout}, 3'b0)
        `CHK("reset_mem_addr", mem_addr, 32'd0)
        reset = 1'b0;
        @(negedge clock);

        run_op(1'b0, 32'h10, 32'h0, 4'd3, 2, 0, -1);
        run_op(1'b1, 32'h20, 32'h12345678, 4'd5, 1, 6, -1);
        run_op(1'b0, 32'h20, 32'h0, 4'd6, 0, 0, -1);
        run_op(1'b1, 32'h24, 32'hCAFEF00D, 4'd7, 0, 4, 2);
        run_op(1'b0, 32'h24, 32'h0, 4'd8, 1, 0, -1);
        run_op(1'b0, 32'h22, 32'h0, 4'd9, 0, 0, -1);
`ifdef MAU_GRANT_TIMEOUT_EN
        run_op(1'b0, 32'h2C, 32'h0, 4'd10, 100000, 0, -1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic        st;
            logic [31:0] addr;
            int          g, c, f;
            st   = 1'($urandom_range(0, 1));
            addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            g = $urandom_range(0, 3);
            c = g + 1 + $urandom_range(0, 4);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, st ? c : g) : -1;
            run_op(st, addr, $urandom, 4'($urandom_range(0, 15)), g, c, f);
        end

        // Reset while a store holds the lock in HOLD.
        op_valid = 1'b1; op_is_store = 1'b1; op_addr = 32'h30; op_wdata = 32'hA5A5A5A5;
        op_issue_id = 4'd12;
        @(posedge clock); #1;
        op_valid = 1'b0; mem_grant = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        `CHK("hold_req_write", mem_req_write, 1'b1)
        @(posedge clock); #1;
        reset = 1'b1; store_commit = 1'b1;
        @(negedge clock);
        `CHK("reset_cycle_no_commit", mem_write_commit, 1'b0)
        @(posedge clock); #1;
        reset = 1'b0; store_commit = 1'b0; mem_grant = 1'b0;
        @(negedge clock);
        `CHK("post_reset_ready", op_ready, 1'b1)
        `CHK("post_reset_mem_addr", mem_addr, 32'd0)
        `CHK("post_reset_mem_wdata", mem_wdata, 32'd0)
        `CHK("post_reset_mem_id", mem_issue_id, 4'd0)
        `CHK("post_reset_ctrl", {mem_req_read, mem_req_write, mem_release_lock, mem_write_commit}, 4'b0)
        `CHK("post_reset_res", res_valid, 1'b0)

        for (int i = 0; i < 16; i++) begin
            `CHK("memory_word", wmem[i], ref_mem[i])
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
